// File: rtl/trap_pkg.sv
// trap_pkg: shared types and constants for the machine-mode trap sequencer
package trap_pkg;
  typedef enum logic [3:0] {
    EXC_INSN_MISALIGN  = 4'd0,
    EXC_INSN_FAULT     = 4'd1,
    EXC_ILLEGAL_INSN   = 4'd2,
    EXC_BREAKPOINT     = 4'd3,
    EXC_LOAD_MISALIGN  = 4'd4,
    EXC_LOAD_FAULT     = 4'd5,
    EXC_STORE_MISALIGN = 4'd6,
    EXC_STORE_FAULT    = 4'd7,
    EXC_ECALL_M        = 4'd11
  } exc_code_t;
  localparam logic [3:0] IRQ_CODE_EXT   = 4'd11;
  localparam logic [3:0] IRQ_CODE_SW    = 4'd3;
  localparam logic [3:0] IRQ_CODE_TIMER = 4'd7;
  typedef enum logic [1:0] {IDLE, FIRE, REFILL} state_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: masks interrupt lines and picks ext > sw > timer
module irq_priority_encoder
  import trap_pkg::*;
(
  input  logic       i_irq_ext,
  input  logic       i_irq_sw,
  input  logic       i_irq_timer,
  input  logic       i_mstatus_mie,
  input  logic [2:0] i_mie,
  input  logic       i_pc_valid,
  output logic       o_irq_valid,
  output logic [3:0] o_irq_code
);
  logic w_gate;
  logic w_ext;
  logic w_sw;
  logic w_timer;
  assign w_gate  = i_mstatus_mie & i_pc_valid;
  assign w_ext   = w_gate & i_irq_ext & i_mie[2];
  assign w_sw    = w_gate & i_irq_sw & i_mie[1];
  assign w_timer = w_gate & i_irq_timer & i_mie[0];
  // fixed-priority selection of the highest eligible interrupt code
  always_comb begin
    o_irq_valid = w_ext | w_sw | w_timer;
    o_irq_code  = w_ext ? IRQ_CODE_EXT : w_sw ? IRQ_CODE_SW : IRQ_CODE_TIMER;
  end
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: arbitrates exceptions/MRET/interrupts, emits redirect and CSR strobes; VECTORED_MTVEC_EN enables vectored interrupt targets
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int REFILL_CYCLES = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_pipl,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [XLEN-1:0] mem_pc,
  input  logic            mem_pc_valid,
  input  logic            mret_req,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            csr_mstatus_mie,
  input  logic [2:0]      csr_mie,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            trap_taken,
  output logic            mret_exec,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mepc_we,
  output logic            mcause_we,
  output logic            mtval_we,
  output logic [XLEN-1:0] mepc_wdata,
  output logic [XLEN-1:0] mcause_wdata,
  output logic [XLEN-1:0] mtval_wdata,
  output logic            mstatus_trap,
  output logic            mstatus_mret
);
  localparam logic [CNT_W-1:0] L_REFILL = CNT_W'(REFILL_CYCLES);
  state_t          r_state;
  state_t          w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic            w_irq_valid;
  logic [3:0]      w_irq_code;
  logic            w_accept;
  logic            w_is_exc;
  logic            w_is_mret;
  logic            w_trap_nx;
  logic            w_mret_nx;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_irq_target;
  logic [XLEN-1:0] w_redirect_nx;
  logic [XLEN-1:0] w_mepc_nx;
  logic [XLEN-1:0] w_mcause_nx;
  logic [XLEN-1:0] w_mtval_nx;

  irq_priority_encoder u_irq_enc (
    .i_irq_ext     (irq_ext),
    .i_irq_sw      (irq_sw),
    .i_irq_timer   (irq_timer),
    .i_mstatus_mie (csr_mstatus_mie),
    .i_mie         (csr_mie),
    .i_pc_valid    (mem_pc_valid),
    .o_irq_valid   (w_irq_valid),
    .o_irq_code    (w_irq_code)
  );

  assign w_base = {csr_mtvec[XLEN-1:2], 2'b00};
`ifdef VECTORED_MTVEC_EN
  assign w_irq_target = (csr_mtvec[1:0] == 2'b01) ?
                        w_base + {{(XLEN-6){1'b0}}, w_irq_code, 2'b00} : w_base;
`else
  logic w_unused_mode;
  assign w_unused_mode = ^csr_mtvec[1:0];
  assign w_irq_target  = w_base;
`endif

  // next state, refill countdown and the registered pulse/data values of the following cycle
  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_accept      = (r_state == IDLE) && !stall_pipl && (exc_valid || mret_req || w_irq_valid);
    w_is_exc      = exc_valid;
    w_is_mret     = !exc_valid && mret_req;
    w_trap_nx     = w_accept && !w_is_mret;
    w_mret_nx     = w_accept && w_is_mret;
    w_redirect_nx = !w_accept ? '0 : w_is_mret ? csr_mepc : w_is_exc ? w_base : w_irq_target;
    w_mepc_nx     = w_trap_nx ? mem_pc : '0;
    w_mcause_nx   = !w_trap_nx ? '0 :
                    w_is_exc ? {{(XLEN-4){1'b0}}, exc_cause} : {1'b1, {(XLEN-5){1'b0}}, w_irq_code};
    w_mtval_nx    = (w_trap_nx && w_is_exc) ? exc_tval : '0;
    if (r_state == IDLE && w_accept) w_state_nx = FIRE;
    if (r_state == FIRE) begin
      w_state_nx = REFILL;
      w_cnt_nx   = L_REFILL;
    end
    if (r_state == REFILL && !stall_pipl) begin
      w_cnt_nx   = r_cnt - 1'b1;
      w_state_nx = (r_cnt <= 1) ? IDLE : REFILL;
    end
  end

  // state register and registered outputs; async reset clears pulses immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      trap_taken   <= 1'b0;
      mret_exec    <= 1'b0;
      redirect_pc  <= '0;
      mepc_we      <= 1'b0;
      mcause_we    <= 1'b0;
      mtval_we     <= 1'b0;
      mepc_wdata   <= '0;
      mcause_wdata <= '0;
      mtval_wdata  <= '0;
      mstatus_trap <= 1'b0;
      mstatus_mret <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      trap_taken   <= w_trap_nx;
      mret_exec    <= w_mret_nx;
      redirect_pc  <= w_redirect_nx;
      mepc_we      <= w_trap_nx;
      mcause_we    <= w_trap_nx;
      mtval_we     <= w_trap_nx;
      mepc_wdata   <= w_mepc_nx;
      mcause_wdata <= w_mcause_nx;
      mtval_wdata  <= w_mtval_nx;
      mstatus_trap <= w_trap_nx;
      mstatus_mret <= w_mret_nx;
    end
  end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed scoreboard bench for trap_sequencer
module tb_trap_sequencer;
  logic        clk = 0;
  logic        reset = 1;
  logic        stall_pipl = 0;
  logic        exc_valid = 0;
  logic [3:0]  exc_cause = 0;
  logic [31:0] exc_tval = 0;
  logic [31:0] mem_pc = 0;
  logic        mem_pc_valid = 1;
  logic        mret_req = 0;
  logic        irq_ext = 0, irq_sw = 0, irq_timer = 0;
  logic        csr_mstatus_mie = 1;
  logic [2:0]  csr_mie = 3'b111;
  logic [31:0] csr_mtvec = 32'h800;
  logic [31:0] csr_mepc = 0;
  logic        trap_taken, mret_exec, mepc_we, mcause_we, mtval_we, mstatus_trap, mstatus_mret;
  logic [31:0] redirect_pc, mepc_wdata, mcause_wdata, mtval_wdata;

  typedef struct {
    logic        trap;
    logic        mret;
    logic [31:0] redirect;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
  } exp_t;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  trap_sequencer dut (
    .clk(clk), .reset(reset), .stall_pipl(stall_pipl), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .exc_tval(exc_tval), .mem_pc(mem_pc), .mem_pc_valid(mem_pc_valid),
    .mret_req(mret_req), .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer),
    .csr_mstatus_mie(csr_mstatus_mie), .csr_mie(csr_mie), .csr_mtvec(csr_mtvec),
    .csr_mepc(csr_mepc), .trap_taken(trap_taken), .mret_exec(mret_exec),
    .redirect_pc(redirect_pc), .mepc_we(mepc_we), .mcause_we(mcause_we), .mtval_we(mtval_we),
    .mepc_wdata(mepc_wdata), .mcause_wdata(mcause_wdata), .mtval_wdata(mtval_wdata),
    .mstatus_trap(mstatus_trap), .mstatus_mret(mstatus_mret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic trap, input logic mret, input logic [31:0] redirect,
                      input logic [31:0] mepc, input logic [31:0] mcause, input logic [31:0] mtval);
    exp_t e;
    e.trap = trap; e.mret = mret; e.redirect = redirect;
    e.mepc = mepc; e.mcause = mcause; e.mtval = mtval;
    sb.push_back(e);
  endtask

  task automatic wait_fire(input string tag, input int lat);
    exp_t e;
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(trap_taken || mret_exec) && n < 20);
    check({tag, "_latency"}, n, lat);
    if (trap_taken || mret_exec) begin
      check({tag, "_sb_nonempty"}, {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, "_trap"}, {31'b0, trap_taken}, {31'b0, e.trap});
        check({tag, "_mret"}, {31'b0, mret_exec}, {31'b0, e.mret});
        check({tag, "_redirect"}, redirect_pc, e.redirect);
        check({tag, "_we"}, {29'b0, mepc_we, mcause_we, mtval_we}, e.trap ? 32'd7 : 32'd0);
        check({tag, "_mepc"}, mepc_wdata, e.mepc);
        check({tag, "_mcause"}, mcause_wdata, e.mcause);
        check({tag, "_mtval"}, mtval_wdata, e.mtval);
        check({tag, "_mstatus"}, {30'b0, mstatus_trap, mstatus_mret}, {30'b0, e.trap, e.mret});
      end
    end
  endtask

  task automatic idle_wait(input string tag);
    tick();
    check({tag, "_one_cycle"}, {31'b0, trap_taken | mret_exec}, 32'd0);
    repeat (3) tick();
  endtask

  task automatic no_pulse(input string tag, input int cycles);
    repeat (cycles) begin
      tick();
      check(tag, {31'b0, trap_taken | mret_exec}, 32'd0);
    end
  endtask

  initial begin
    tick();
    tick();
    check("reset_pulses", {30'b0, trap_taken, mret_exec}, 32'd0);
    check("reset_redirect", redirect_pc, 32'd0);
    check("reset_wdata", mepc_wdata | mcause_wdata | mtval_wdata, 32'd0);
    reset = 0;
    no_pulse("idle_quiet", 2);

    // synchronous exception, then holdoff while it stays asserted
    exc_valid = 1; exc_cause = 4'd2; mem_pc = 32'h100; exc_tval = 32'hDEAD;
    push(1, 0, 32'h800, 32'h100, 32'h2, 32'hDEAD);
    wait_fire("exc", 1);
    push(1, 0, 32'h800, 32'h100, 32'h2, 32'hDEAD);
    wait_fire("exc_refill", 5);
    exc_valid = 0;
    idle_wait("exc");

    // timer interrupt; vectored target only when the feature is built in
    csr_mtvec = 32'h801; irq_timer = 1; mem_pc = 32'h204;
`ifdef VECTORED_MTVEC_EN
    push(1, 0, 32'h81C, 32'h204, 32'h80000007, 32'h0);
`else
    push(1, 0, 32'h800, 32'h204, 32'h80000007, 32'h0);
`endif
    wait_fire("irq_timer", 1);
    irq_timer = 0;
    idle_wait("irq_timer");
    csr_mtvec = 32'h800;

    // ext beats timer; timer follows after refill
    irq_ext = 1; irq_timer = 1; mem_pc = 32'h208;
    push(1, 0, 32'h800, 32'h208, 32'h8000000B, 32'h0);
    wait_fire("irq_ext", 1);
    irq_ext = 0;
    push(1, 0, 32'h800, 32'h208, 32'h80000007, 32'h0);
    wait_fire("irq_timer_after", 5);
    irq_timer = 0;
    idle_wait("irq_pair");

    // MRET alone
    mret_req = 1; csr_mepc = 32'h344;
    push(0, 1, 32'h344, 32'h0, 32'h0, 32'h0);
    wait_fire("mret", 1);
    mret_req = 0;
    idle_wait("mret");

    // MRET with exception in the same cycle
    mret_req = 1; exc_valid = 1; exc_cause = 4'd11; mem_pc = 32'h300; exc_tval = 32'h0;
    push(1, 0, 32'h800, 32'h300, 32'hB, 32'h0);
    wait_fire("exc_over_mret", 1);
    mret_req = 0; exc_valid = 0;
    idle_wait("exc_over_mret");

    // stall in IDLE delays accept; stall in REFILL freezes the countdown
    stall_pipl = 1; exc_valid = 1; exc_cause = 4'd5; mem_pc = 32'h400; exc_tval = 32'h1234;
    no_pulse("stall_hold", 4);
    stall_pipl = 0;
    push(1, 0, 32'h800, 32'h400, 32'h5, 32'h1234);
    wait_fire("stall_release", 1);
    stall_pipl = 1;
    no_pulse("stall_refill", 2);
    stall_pipl = 0;
    push(1, 0, 32'h800, 32'h400, 32'h5, 32'h1234);
    wait_fire("stall_frozen", 4);
    exc_valid = 0;
    idle_wait("stall");

    // async reset during FIRE clears the pulse immediately
    exc_valid = 1; exc_cause = 4'd1; mem_pc = 32'h500; exc_tval = 32'h77;
    tick();
    check("fire_before_reset", {31'b0, trap_taken}, 32'd1);
    #2 reset = 1;
    #1;
    check("reset_in_fire", {31'b0, trap_taken}, 32'd0);
    check("reset_in_fire_redirect", redirect_pc, 32'd0);
    #2 reset = 0; exc_valid = 0;
    push(1, 0, 32'h800, 32'h504, 32'h1, 32'h88);
    exc_valid = 1; mem_pc = 32'h504; exc_tval = 32'h88;
    wait_fire("after_reset", 1);
    exc_valid = 0;
    idle_wait("after_reset");

    // global MIE=0 masks every interrupt; a bubble also blocks interrupts
    csr_mstatus_mie = 0; irq_ext = 1; irq_sw = 1; irq_timer = 1;
    no_pulse("mie_masked", 3);
    csr_mstatus_mie = 1; mem_pc_valid = 0;
    no_pulse("bubble_masked", 2);
    irq_ext = 0; irq_timer = 0; mem_pc_valid = 1; mem_pc = 32'h600;
    push(1, 0, 32'h800, 32'h600, 32'h80000003, 32'h0);
    wait_fire("irq_sw", 1);
    irq_sw = 0;
    idle_wait("irq_sw");
    no_pulse("irq_dropped", 2);

    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
